morse_key_sequencer: RTL and testbench

Controller that drives the Morse-to-text entry datapath from three physical keys instead of five buttons. It debounces a single telegraph key and times each press: a short press becomes a dot, a long press becomes a dash, and a long release gap commits the letter. It also generates the delete and clear strobes, and tracks symbol and slot occupancy so the datapath is never driven past its 4-symbol / 8-slot limits. Outputs connect directly to the datapath's dot, dash, commit, reset and delete button inputs.

---
 rtl/morse_key_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_morse_key_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_sequencer.sv
// Three-key Morse entry controller: debounces key/delete/clear, times presses into dot/dash, commits on gap.
// Optional MORSE_AUTO_COMMIT_EN commits a letter as soon as its 4th symbol is entered.
module morse_key_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DASH_CYCLES     = 30_000_000,
  parameter int GAP_CYCLES      = 60_000_000,
  parameter int CNT_W           = 27
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_in,
  input  logic       del_in,
  input  logic       clr_in,
  output logic       dot_pulse,
  output logic       dash_pulse,
  output logic       commit_pulse,
  output logic       delete_pulse,
  output logic       clear_pulse,
  output logic [2:0] sym_cnt,
  output logic [3:0] slot_cnt,
  output logic       overflow
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_DISCARD} state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_MAX = CNT_W'(DASH_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  logic [2:0] raw_in;
  logic [2:0] lvl;
  logic [2:0] edge_ev;
  logic       key_sync;

  assign raw_in = {clr_in, del_in, key_in};

  // Per input: 2-flop synchronizer, then a level that flips after DEBOUNCE_CYCLES of disagreement.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      logic             s1_q, s2_q, lvl_q, edge_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          lvl_q  <= 1'b0;
          edge_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          s1_q   <= raw_in[gi];
          s2_q   <= s1_q;
          edge_q <= 1'b0;
          if (s2_q == lvl_q) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_LAST) begin
            cnt_q  <= '0;
            lvl_q  <= s2_q;
            edge_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end

      assign lvl[gi]     = lvl_q;
      assign edge_ev[gi] = edge_q;
      if (gi == 0) begin : g_key
        assign key_sync = s2_q;
      end
    end
  endgenerate

  // A key held through reset must be seen released before its next rise can start a press.
  logic             armed_q;
  logic [CNT_W-1:0] arm_cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else if (!armed_q) begin
      if (key_sync) begin
        arm_cnt_q <= '0;
      end else if (arm_cnt_q == DB_LAST) begin
        armed_q <= 1'b1;
      end else begin
        arm_cnt_q <= arm_cnt_q + 1'b1;
      end
    end
  end

  logic key_rise, key_fall, del_rise, clr_rise;
  logic ev_rise, ev_fall, ev_del, ev_clr, busy;

  state_t           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [2:0]       sym_q;
  logic [3:0]       slot_q;
  logic             ovf_q;
  logic             dot_q, dash_q, commit_q, delete_q, clear_q;
  logic             pend_rise_q, pend_fall_q, pend_del_q, pend_clr_q;

  assign key_rise = edge_ev[0] & lvl[0] & armed_q;
  assign key_fall = edge_ev[0] & ~lvl[0];
  assign del_rise = edge_ev[1] & lvl[1];
  assign clr_rise = edge_ev[2] & lvl[2];

  assign ev_rise = key_rise | pend_rise_q;
  assign ev_fall = key_fall | pend_fall_q;
  assign ev_del  = del_rise | pend_del_q;
  assign ev_clr  = clr_rise | pend_clr_q;
  // Events landing while a pulse is high wait one cycle so the datapath always sees a low between strobes.
  assign busy    = dot_q | dash_q | commit_q | delete_q | clear_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      sym_q       <= '0;
      slot_q      <= '0;
      ovf_q       <= 1'b0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      commit_q    <= 1'b0;
      delete_q    <= 1'b0;
      clear_q     <= 1'b0;
      pend_rise_q <= 1'b0;
      pend_fall_q <= 1'b0;
      pend_del_q  <= 1'b0;
      pend_clr_q  <= 1'b0;
    end else begin
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      commit_q <= 1'b0;
      delete_q <= 1'b0;
      clear_q  <= 1'b0;
      case (state_q)
        S_PRESS: if (timer_q < DASH_MAX) timer_q <= timer_q + 1'b1;
        S_GAP:   timer_q <= timer_q + 1'b1;
        default: timer_q <= '0;
      endcase

      if (busy) begin
        pend_rise_q <= ev_rise;
        pend_fall_q <= ev_fall;
        pend_del_q  <= ev_del;
        pend_clr_q  <= ev_clr;
      end else begin
        pend_rise_q <= 1'b0;
        pend_fall_q <= 1'b0;
        pend_del_q  <= 1'b0;
        pend_clr_q  <= 1'b0;
        if (ev_clr) begin
          clear_q <= 1'b1;
          sym_q   <= '0;
          slot_q  <= '0;
          ovf_q   <= 1'b0;
          timer_q <= '0;
          state_q <= (state_q == S_PRESS) ? S_DISCARD : S_IDLE;
        end else if (ev_del) begin
          if (sym_q == 3'd0 && slot_q != 4'd0) begin
            delete_q <= 1'b1;
            slot_q   <= slot_q - 4'd1;
          end
        end else begin
`ifdef MORSE_AUTO_COMMIT_EN
          if (sym_q == 3'd4) begin
            sym_q   <= '0;
            timer_q <= '0;
            state_q <= S_GAP;
            if (slot_q == 4'd8) begin
              ovf_q <= 1'b1;
            end else begin
              commit_q <= 1'b1;
              slot_q   <= slot_q + 4'd1;
            end
          end else
`endif
          case (state_q)
            S_IDLE: begin
              if (ev_rise) begin
                state_q <= S_PRESS;
                timer_q <= '0;
              end
            end
            S_PRESS: begin
              if (ev_fall) begin
                if (sym_q == 3'd4 || slot_q == 4'd8) begin
                  ovf_q <= 1'b1;
                end else begin
                  dash_q <= (timer_q == DASH_MAX);
                  dot_q  <= (timer_q != DASH_MAX);
                  sym_q  <= sym_q + 3'd1;
                end
                state_q <= S_GAP;
                timer_q <= '0;
              end
            end
            S_GAP: begin
              if (ev_rise) begin
                state_q <= S_PRESS;
                timer_q <= '0;
              end else if (timer_q >= GAP_LAST) begin
                state_q <= S_IDLE;
                timer_q <= '0;
                if (sym_q != 3'd0) begin
                  sym_q <= '0;
                  if (slot_q == 4'd8) begin
                    ovf_q <= 1'b1;
                  end else begin
                    commit_q <= 1'b1;
                    slot_q   <= slot_q + 4'd1;
                  end
                end
              end
            end
            default: begin
              if (!lvl[0]) state_q <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign dot_pulse    = dot_q;
  assign dash_pulse   = dash_q;
  assign commit_pulse = commit_q;
  assign delete_pulse = delete_q;
  assign clear_pulse  = clear_q;
  assign sym_cnt      = sym_q;
  assign slot_cnt     = slot_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with short timing parameters (debounce 4, dash 20, gap 50).
module tb_morse_key_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       key_in, del_in, clr_in;
  logic       dot_pulse, dash_pulse, commit_pulse, delete_pulse, clear_pulse;
  logic [2:0] sym_cnt;
  logic [3:0] slot_cnt;
  logic       overflow;

  morse_key_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .DASH_CYCLES    (20),
    .GAP_CYCLES     (50),
    .CNT_W          (27)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_in       (key_in),
    .del_in       (del_in),
    .clr_in       (clr_in),
    .dot_pulse    (dot_pulse),
    .dash_pulse   (dash_pulse),
    .commit_pulse (commit_pulse),
    .delete_pulse (delete_pulse),
    .clear_pulse  (clear_pulse),
    .sym_cnt      (sym_cnt),
    .slot_cnt     (slot_cnt),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Pulse tallies and back-to-back strobe detection, sampled on the falling edge.
  int   dot_n = 0, dash_n = 0, commit_n = 0, delete_n = 0, clear_n = 0, adj_n = 0;
  logic prev_any = 1'b0;
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      dot_n    += int'(dot_pulse);
      dash_n   += int'(dash_pulse);
      commit_n += int'(commit_pulse);
      delete_n += int'(delete_pulse);
      clear_n  += int'(clear_pulse);
      if ((dot_pulse | dash_pulse | commit_pulse | delete_pulse | clear_pulse) && prev_any) adj_n++;
      prev_any = dot_pulse | dash_pulse | commit_pulse | delete_pulse | clear_pulse;
    end else begin
      prev_any = 1'b0;
    end
  end

  int b_dot, b_dash, b_commit, b_delete, b_clear;

  task automatic snap();
    b_dot = dot_n; b_dash = dash_n; b_commit = commit_n; b_delete = delete_n; b_clear = clear_n;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic press(input int hold, input int rel);
    key_in = 1'b1;
    tick(hold);
    key_in = 1'b0;
    tick(rel);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; key_in = 1'b0; del_in = 1'b0; clr_in = 1'b0;
    tick(3);
    check("rst_pulses", {27'd0, dot_pulse, dash_pulse, commit_pulse, delete_pulse, clear_pulse}, 0);
    check("rst_counts", {24'd0, sym_cnt, slot_cnt, overflow}, 0);
    reset_n = 1'b1;
    tick(10);

    // Short press then long release: dot, then commit on gap timeout.
    snap();
    key_in = 1'b1; tick(10); key_in = 1'b0; tick(30);
    check("s1_dot", dot_n - b_dot, 1);
    check("s1_sym1", sym_cnt, 1);
    check("s1_nocommit_yet", commit_n - b_commit, 0);
    tick(40);
    check("s1_commit", commit_n - b_commit, 1);
    check("s1_sym0", sym_cnt, 0);
    check("s1_slot1", slot_cnt, 1);

    // Long press gives a dash only.
    snap();
    press(30, 70);
    check("s2_dash", dash_n - b_dash, 1);
    check("s2_nodot", dot_n - b_dot, 0);
    check("s2_slot2", slot_cnt, 2);

    // 3-cycle glitch is swallowed by the debouncer.
    snap();
    key_in = 1'b1; tick(3); key_in = 1'b0; tick(20);
    check("glitch_nosym", (dot_n - b_dot) + (dash_n - b_dash), 0);
    check("glitch_sym0", sym_cnt, 0);

    // Five quick presses.
    snap();
    for (int i = 0; i < 4; i++) press(10, 10);
    press(10, 15);
`ifdef MORSE_AUTO_COMMIT_EN
    check("five_dots", dot_n - b_dot, 5);
    check("five_commit", commit_n - b_commit, 1);
    check("five_sym", sym_cnt, 1);
    check("five_ovf", overflow, 0);
    tick(60);
    check("five_slot", slot_cnt, 4);
`else
    check("five_dots", dot_n - b_dot, 4);
    check("five_commit", commit_n - b_commit, 0);
    check("five_sym", sym_cnt, 4);
    check("five_ovf", overflow, 1);
    tick(60);
    check("five_slot", slot_cnt, 3);
    check("five_ovf_sticky", overflow, 1);
`endif
    check("five_gap_sym0", sym_cnt, 0);

    // Clear resets counters and overflow.
    snap();
    clr_in = 1'b1; tick(10); clr_in = 1'b0; tick(10);
    check("clr1_pulse", clear_n - b_clear, 1);
    check("clr1_counts", {24'd0, sym_cnt, slot_cnt, overflow}, 0);

    // Delete and clear debounced in the same cycle: clear wins.
    for (int i = 0; i < 3; i++) press(10, 70);
    check("dc_slot3", slot_cnt, 3);
    snap();
    del_in = 1'b1; clr_in = 1'b1; tick(10);
    del_in = 1'b0; clr_in = 1'b0; tick(10);
    check("dc_clear", clear_n - b_clear, 1);
    check("dc_nodelete", delete_n - b_delete, 0);
    check("dc_slot0", slot_cnt, 0);

    // Fill all 8 slots, then a further dot is dropped.
    snap();
    for (int i = 0; i < 8; i++) press(10, 70);
    check("full_commits", commit_n - b_commit, 8);
    check("full_slot8", slot_cnt, 8);
    check("full_ovf0", overflow, 0);
    snap();
    press(10, 70);
    check("full_nodot", dot_n - b_dot, 0);
    check("full_nocommit", commit_n - b_commit, 0);
    check("full_ovf1", overflow, 1);
    check("full_slot_stays", slot_cnt, 8);

    snap();
    del_in = 1'b1; tick(10); del_in = 1'b0; tick(10);
    check("del_pulse", delete_n - b_delete, 1);
    check("del_slot7", slot_cnt, 7);

    snap();
    clr_in = 1'b1; tick(10); clr_in = 1'b0; tick(10);
    check("clr2_pulse", clear_n - b_clear, 1);
    check("clr2_counts", {24'd0, sym_cnt, slot_cnt, overflow}, 0);

    // Reset mid-press with two symbols pending; the held key's release must not emit.
    press(10, 10);
    press(10, 10);
    check("rp_sym2", sym_cnt, 2);
    key_in = 1'b1; tick(12);
    reset_n = 1'b0;
    #1;
    check("rp_async_pulses", {27'd0, dot_pulse, dash_pulse, commit_pulse, delete_pulse, clear_pulse}, 0);
    check("rp_async_counts", {24'd0, sym_cnt, slot_cnt, overflow}, 0);
    tick(1);
    reset_n = 1'b1;
    snap();
    tick(10);
    key_in = 1'b0; tick(20);
    check("rp_nosym", (dot_n - b_dot) + (dash_n - b_dash), 0);
    check("rp_sym0", sym_cnt, 0);
    snap();
    press(10, 70);
    check("rp_recover_dot", dot_n - b_dot, 1);
    check("rp_recover_slot", slot_cnt, 1);

    check("pulse_spacing", adj_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
